// File: rtl/psram_arbiter.sv
// Single-port PSRAM command arbiter: read priority, writer starvation bound, WAIT watchdog.
// Define PSRAM_ARB_STATS_EN to add grant counters and the starve_force pulse.
module psram_arbiter #(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [DATA_W-1:0] mem_cmd_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  input  logic              mem_done,
  output logic              busy,
  output logic              err_timeout
`ifdef PSRAM_ARB_STATS_EN
  ,
  output logic [15:0]       rd_grant_cnt,
  output logic [15:0]       wr_grant_cnt,
  output logic              starve_force
`endif
);

  // Handshakes: rd_req/wr_req are levels held until their same-cycle ack pulse;
  // mem_cmd_valid stays high with a stable payload until the cycle mem_cmd_ready is seen.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [7:0]  LP_STARVE_MAX = 8'(STARVE_MAX);
  localparam logic [15:0] LP_TOUT_LAST  = 16'(TIMEOUT - 1);

  state_t              r_state, w_state_nxt;
  logic                w_grant_rd, w_grant_wr;
  logic                w_rsp_hit, w_done_hit, w_tout_hit;
  logic [7:0]          r_starve_cnt;
  logic [15:0]         r_tout_cnt;
  logic                r_fin;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_cmd_valid;
  logic                r_cmd_we;
  logic [ADDR_W-1:0]   r_cmd_addr;
  logic [DATA_W-1:0]   r_cmd_wdata;
  logic                r_err_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_rd  = 1'b0;
    w_grant_wr  = 1'b0;
    w_rsp_hit   = 1'b0;
    w_done_hit  = 1'b0;
    w_tout_hit  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Gated by rst_n so acks stay low while reset is held.
        if (rst_n) begin
          if (wr_req && (!rd_req || r_starve_cnt == LP_STARVE_MAX)) w_grant_wr = 1'b1;
          else if (rd_req)                                          w_grant_rd = 1'b1;
          if (w_grant_wr || w_grant_rd) w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: if (mem_cmd_ready) w_state_nxt = S_WAIT;
      S_WAIT: begin
        // r_fin marks the extra cycle that presents rd_valid before returning to IDLE.
        if (r_fin) w_state_nxt = S_IDLE;
        else begin
          w_rsp_hit  = !r_cmd_we && mem_rsp_valid;
          w_done_hit = r_cmd_we && mem_done;
          w_tout_hit = !w_rsp_hit && !w_done_hit && (r_tout_cnt == LP_TOUT_LAST);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt  <= '0;
      r_tout_cnt    <= '0;
      r_fin         <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_data     <= '0;
      r_cmd_valid   <= 1'b0;
      r_cmd_we      <= 1'b0;
      r_cmd_addr    <= '0;
      r_cmd_wdata   <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_grant_wr || w_grant_rd) begin
        r_cmd_valid <= 1'b1;
        r_cmd_we    <= w_grant_wr;
        r_cmd_addr  <= w_grant_wr ? wr_addr : rd_addr;
        r_cmd_wdata <= w_grant_wr ? wr_data : '0;
      end
      if (w_grant_wr) r_starve_cnt <= '0;
      else if (w_grant_rd) begin
        if (!wr_req)                            r_starve_cnt <= '0;
        else if (r_starve_cnt != LP_STARVE_MAX) r_starve_cnt <= r_starve_cnt + 8'd1;
      end
      if (r_state == S_ISSUE && mem_cmd_ready) begin
        r_cmd_valid <= 1'b0;
        r_tout_cnt  <= '0;
      end
      if (r_state == S_WAIT) begin
        if (r_fin) r_fin <= 1'b0;
        else if (w_rsp_hit) begin
          r_rd_data  <= mem_rsp_rdata;
          r_rd_valid <= 1'b1;
          r_fin      <= 1'b1;
        end else if (w_done_hit) r_fin <= 1'b1;
        else if (w_tout_hit) begin
          r_err_timeout <= 1'b1;
          r_fin         <= 1'b1;
          if (!r_cmd_we) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= '0;
          end
        end else r_tout_cnt <= r_tout_cnt + 16'd1;
      end
    end
  end

  assign rd_ack        = w_grant_rd;
  assign wr_ack        = w_grant_wr;
  assign rd_valid      = r_rd_valid;
  assign rd_data       = r_rd_data;
  assign mem_cmd_valid = r_cmd_valid;
  assign mem_cmd_we    = r_cmd_we;
  assign mem_cmd_addr  = r_cmd_addr;
  assign mem_cmd_wdata = r_cmd_wdata;
  assign busy          = (r_state != S_IDLE);
  assign err_timeout   = r_err_timeout;

`ifdef PSRAM_ARB_STATS_EN
  logic [15:0] r_rd_grant_cnt, r_wr_grant_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_grant_cnt <= '0;
      r_wr_grant_cnt <= '0;
    end else begin
      if (w_grant_rd && r_rd_grant_cnt != 16'hFFFF) r_rd_grant_cnt <= r_rd_grant_cnt + 16'd1;
      if (w_grant_wr && r_wr_grant_cnt != 16'hFFFF) r_wr_grant_cnt <= r_wr_grant_cnt + 16'd1;
    end
  end

  assign rd_grant_cnt = r_rd_grant_cnt;
  assign wr_grant_cnt = r_wr_grant_cnt;
  assign starve_force = w_grant_wr && rd_req;
`endif

endmodule

// File: tb/tb_psram_arbiter.sv
// Randomized scoreboard bench for psram_arbiter with a PSRAM controller model and arbitration reference.
module tb_psram_arbiter;
  localparam int TB_STARVE = 8;
  localparam int TB_TOUT   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req, rd_ack, rd_valid;
  logic [22:0] rd_addr;
  logic [7:0]  rd_data;
  logic        wr_req, wr_ack;
  logic [22:0] wr_addr;
  logic [7:0]  wr_data;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
  logic [22:0] mem_cmd_addr;
  logic [7:0]  mem_cmd_wdata;
  logic        mem_rsp_valid, mem_done;
  logic [7:0]  mem_rsp_rdata;
  logic        busy, err_timeout;
`ifdef PSRAM_ARB_STATS_EN
  logic [15:0] rd_grant_cnt, wr_grant_cnt;
  logic        starve_force;
`endif

  psram_arbiter #(.ADDR_W(23), .DATA_W(8), .STARVE_MAX(TB_STARVE), .TIMEOUT(TB_TOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_done(mem_done),
    .busy(busy), .err_timeout(err_timeout)
`ifdef PSRAM_ARB_STATS_EN
    , .rd_grant_cnt(rd_grant_cnt), .wr_grant_cnt(wr_grant_cnt), .starve_force(starve_force)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared state ----------------
  logic [23:0] rd_pend_q[$];   // {drop, addr}
  logic [30:0] wr_pend_q[$];   // {addr, data}
  logic [8:0]  exp_q[$];       // {timeout, rd_data}
  logic [31:0] cmd_q[$];       // {we, addr, wdata}
  bit          beh_q[$];       // controller drops the response
  int n_vec = 0, n_err = 0;
  int m_starve = 0, n_rd_grants = 0, n_wr_grants = 0;
  bit m_err = 0;
  logic [7:0] held = '0;
  bit rand_mode = 0, ovr_en = 0;
  logic [7:0] ovr_val = '0;
  int rdy_dly = 0, rsp_dly = 0;

  function automatic logic [7:0] rdata_of(input logic [22:0] a);
    return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- requester driver + arbitration reference ----------------
  initial begin
    bit exp_r, exp_w;
    logic [23:0] ri;
    logic [30:0] wi;
    rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0; wr_data = '0;
    forever begin
      @(posedge clk); #1;
      rd_req = rst_n && rd_pend_q.size() > 0;
      if (rd_req) rd_addr = rd_pend_q[0][22:0];
      wr_req = rst_n && wr_pend_q.size() > 0;
      if (wr_req) begin
        wr_addr = wr_pend_q[0][30:8];
        wr_data = wr_pend_q[0][7:0];
      end
      @(negedge clk);
      if (!rst_n) continue;
      exp_w = wr_req && (!rd_req || m_starve == TB_STARVE);
      exp_r = !exp_w && rd_req;
      if (busy) begin
        if (rd_req || wr_req) chk("ack_while_busy", {rd_ack, wr_ack}, 0);
      end else if (rd_req || wr_req) begin
        chk("grant", {rd_ack, wr_ack}, {exp_r, exp_w});
`ifdef PSRAM_ARB_STATS_EN
        chk("starve_force", starve_force, exp_w && rd_req);
`endif
      end
      if (rd_ack && rd_req) begin
        ri = rd_pend_q.pop_front();
        exp_q.push_back({ri[23], ri[23] ? 8'h00 : (ovr_en ? ovr_val : rdata_of(ri[22:0]))});
        cmd_q.push_back({1'b0, ri[22:0], 8'h00});
        beh_q.push_back(ri[23]);
        if (!wr_req) m_starve = 0;
        else if (m_starve < TB_STARVE) m_starve++;
        n_rd_grants++;
      end
      if (wr_ack && wr_req) begin
        wi = wr_pend_q.pop_front();
        cmd_q.push_back({1'b1, wi});
        beh_q.push_back(1'b0);
        m_starve = 0;
        n_wr_grants++;
      end
    end
  end

  // ---------------- PSRAM controller model ----------------
  initial begin
    int m_phase, m_cnt;
    bit m_we, m_drop, m_spur;
    logic [22:0] m_addr;
    mem_cmd_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0; mem_done = 0;
    m_phase = 0; m_cnt = 0; m_we = 0; m_drop = 0; m_spur = 0; m_addr = '0;
    forever begin
      @(posedge clk); #1;
      mem_cmd_ready = 0; mem_rsp_valid = 0; mem_done = 0;
      if (!rst_n) begin m_phase = 0; continue; end
      if (m_phase == 0 && mem_cmd_valid) begin
        m_cnt = rand_mode ? int'($urandom_range(0, 3)) : rdy_dly;
        m_phase = 1;
      end
      if (m_phase == 1) begin
        if (m_cnt == 0) begin
          mem_cmd_ready = 1;
          m_we = mem_cmd_we;
          m_addr = mem_cmd_addr;
          m_drop = (beh_q.size() > 0) ? beh_q.pop_front() : 1'b0;
          m_cnt = rand_mode ? int'($urandom_range(0, 3)) : rsp_dly;
          m_spur = rand_mode && ($urandom_range(0, 1) == 1);
          m_phase = 2;
        end else m_cnt--;
      end else if (m_phase == 2) begin
        if (m_drop) m_phase = 0;
        else if (m_cnt == 0) begin
          if (m_we) mem_done = 1;
          else begin
            mem_rsp_valid = 1;
            mem_rsp_rdata = ovr_en ? ovr_val : rdata_of(m_addr);
          end
          m_phase = 0;
        end else begin
          m_cnt--;
          if (m_spur) begin
            if (m_we) begin mem_rsp_valid = 1; mem_rsp_rdata = 8'hEE; end
            else mem_done = 1;
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit prev_ack = 0, cur_we = 0;
    int hs_cyc = -100, rsp_cyc = -100;
    logic [31:0] ce;
    logic [8:0]  re;
    forever begin
      @(negedge clk);
      if (!rst_n) begin prev_ack = 0; continue; end
      if (prev_ack) chk("ack_to_cmd_valid", mem_cmd_valid, 1);
      prev_ack = rd_ack || wr_ack;
      if (mem_cmd_valid) begin
        if (cmd_q.size() == 0) chk("cmd_unexpected", mem_cmd_valid, 0);
        else begin
          ce = cmd_q[0];
          chk("cmd_we", mem_cmd_we, ce[31]);
          chk("cmd_addr", mem_cmd_addr, ce[30:8]);
          if (ce[31]) chk("cmd_wdata", mem_cmd_wdata, ce[7:0]);
          if (mem_cmd_ready) begin
            void'(cmd_q.pop_front());
            hs_cyc = cyc;
            cur_we = ce[31];
          end
        end
      end
      if (mem_rsp_valid && !cur_we) rsp_cyc = cyc;
      if (rd_valid) begin
        if (exp_q.size() == 0) chk("rd_valid_unexpected", rd_valid, 0);
        else begin
          re = exp_q.pop_front();
          chk("rd_data", rd_data, re[7:0]);
          held = re[7:0];
          if (re[8]) begin
            m_err = 1;
            chk("timeout_flag", err_timeout, 1);
            chk("timeout_latency", cyc - hs_cyc, TB_TOUT + 1);
          end else begin
            chk("rd_latency", cyc - rsp_cyc, 1);
            chk("err_sticky", err_timeout, m_err);
          end
        end
      end else chk("rd_data_hold", rd_data, held);
    end
  end

  // ---------------- test sequence ----------------
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_acks"}, {rd_ack, wr_ack, rd_valid}, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_cmd_ctl"}, {mem_cmd_valid, mem_cmd_we}, 0);
    chk({tag, "_cmd_addr"}, mem_cmd_addr, 0);
    chk({tag, "_cmd_wdata"}, mem_cmd_wdata, 0);
    chk({tag, "_busy_err"}, {busy, err_timeout}, 0);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!(rd_pend_q.size() == 0 && wr_pend_q.size() == 0 && exp_q.size() == 0 &&
             cmd_q.size() == 0 && !busy && !rd_req && !wr_req)) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        chk("drain_budget", n, budget);
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0;
    repeat (3) @(posedge clk);
    #2 check_reset_outputs("por");
    #1 rst_n = 1;

    // single read with controller answer two cycles after ready
    ovr_en = 1; ovr_val = 8'hA5; rsp_dly = 1;
    rd_pend_q.push_back({1'b0, 23'h00_1234});
    wait_drain(200);
    chk("busy_after_read", busy, 0);
    ovr_en = 0; rsp_dly = 0;

    // single write with ready held off
    rdy_dly = 5;
    wr_pend_q.push_back({23'h40_0000, 8'h3C});
    wait_drain(200);
    rdy_dly = 0;

    // simultaneous arrival, read first
    rd_pend_q.push_back({1'b0, 23'h00_0010});
    wr_pend_q.push_back({23'h00_0020, 8'h11});
    wait_drain(200);

    // starvation: both held continuously
    for (int i = 0; i < 20; i++) rd_pend_q.push_back({1'b0, 23'(24'h1000 + i)});
    for (int i = 0; i < 3; i++) wr_pend_q.push_back({23'(24'h2000 + i), 8'(i + 8'h70)});
    wait_drain(2000);

    // watchdog on a dropped read, then a normal read and write
    rd_pend_q.push_back({1'b1, 23'h0A_BCDE});
    rd_pend_q.push_back({1'b0, 23'h0A_BCDF});
    wr_pend_q.push_back({23'h12_3456, 8'h99});
    wait_drain(500);

    // randomized traffic
    rand_mode = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1)
        rd_pend_q.push_back({($urandom_range(0, 9) == 0), 23'($urandom)});
      else
        wr_pend_q.push_back({23'($urandom), 8'($urandom)});
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    wait_drain(6000);
    rand_mode = 0;

    // reset while a read sits in WAIT
    rd_pend_q.push_back({1'b1, 23'h00_1111});
    repeat (8) @(posedge clk);
    chk("busy_in_wait", busy, 1);
    #3 rst_n = 0;
    #1 check_reset_outputs("mid_wait");
    rd_pend_q.delete(); wr_pend_q.delete(); exp_q.delete(); cmd_q.delete(); beh_q.delete();
    m_starve = 0; m_err = 0; held = '0; n_rd_grants = 0; n_wr_grants = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    repeat (25) @(posedge clk);
    rd_pend_q.push_back({1'b0, 23'h00_2222});
    wait_drain(200);
`ifdef PSRAM_ARB_STATS_EN
    chk("rd_grant_cnt", rd_grant_cnt, n_rd_grants);
    chk("wr_grant_cnt", wr_grant_cnt, n_wr_grants);
`endif

    chk("exp_q_empty", exp_q.size(), 0);
    chk("cmd_q_empty", cmd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
